// File: rtl/hist_readout_streamer_pkg.sv
// Shared types and helpers for the histogram readout streamer.
package hist_readout_streamer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_HDR       = 3'd1;
  localparam state_t ST_RD_WAIT   = 3'd2;
  localparam state_t ST_SEND_IDX  = 3'd3;
  localparam state_t ST_SEND_DATA = 3'd4;
  localparam state_t ST_SEND_SUM  = 3'd5;
  localparam state_t ST_DONE      = 3'd6;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  // Number of bytes needed to carry one bin counter.
  function automatic int unsigned nb_bytes(input int unsigned data_w);
    return (data_w + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/hist_readout_streamer_if.sv
// Histogram select/data port plus outgoing byte stream.
interface hist_readout_streamer_if #(
  parameter int unsigned SEL_W  = 8,
  parameter int unsigned DATA_W = 16
);
  logic              freeze;
  logic [SEL_W-1:0]  hist_sel;
  logic [DATA_W-1:0] hist_data;
  logic              bin_clr;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output freeze, hist_sel, bin_clr, tx_data, tx_valid,
    input  hist_data, tx_ready
  );

  modport slave (
    input  freeze, hist_sel, bin_clr, tx_data, tx_valid,
    output hist_data, tx_ready
  );
endinterface

// File: rtl/hist_byte_serializer.sv
// Holds one bin counter and hands it out a byte at a time, MSB first.
// byte_c is the next byte to hand out; last_c is high once every byte
// of the loaded word has been popped.
module hist_byte_serializer
  import hist_readout_streamer_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              pop,
  output logic [7:0]        byte_c,
  output logic              last_c
);
  localparam int unsigned NB    = nb_bytes(DATA_W);
  localparam int unsigned SH_W  = NB * 8;
  localparam int unsigned CNT_W = $clog2(NB + 1);

  logic [SH_W-1:0]  shreg_q;
  logic [CNT_W-1:0] cnt_q;

  // Load zero-padded word, shift out one byte per pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shreg_q <= SH_W'(word);
      cnt_q   <= CNT_W'(NB);
    end else if (pop) begin
      shreg_q <= shreg_q << 8;
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

  assign byte_c = shreg_q[SH_W-1 -: 8];
  assign last_c = (cnt_q == '0);

endmodule

// File: rtl/hist_readout_streamer.sv
// Freezes the histogram logger, scans every bin and streams a framed,
// XOR-checksummed byte dump. Optional macro HIST_CLEAR_ON_READ_EN clears
// each bin as its last data byte leaves.
module hist_readout_streamer
  import hist_readout_streamer_pkg::*;
#(
  parameter int unsigned NUM_BINS = 256,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RD_LAT   = 1,
  parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done,
  hist_readout_streamer_if.master bus
);
  localparam int unsigned SEL_W = $clog2(NUM_BINS);
  localparam int unsigned LAT_W = 2;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_BINS - 1);

  state_t           state_q, state_d;
  logic             busy_d, done_d;
  logic             freeze_q, freeze_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       sum_q, sum_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             accept_c;
  logic             ser_load_c, ser_pop_c, ser_last_c;
  logic [7:0]       ser_byte_c;

  assign accept_c = tx_valid_q & bus.tx_ready;

  hist_byte_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (ser_load_c),
    .word    (bus.hist_data),
    .pop     (ser_pop_c),
    .byte_c  (ser_byte_c),
    .last_c  (ser_last_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      freeze_q   <= 1'b0;
      sel_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      sum_q      <= '0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy       <= busy_d;
      done       <= done_d;
      freeze_q   <= freeze_d;
      sel_q      <= sel_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      sum_q      <= sum_d;
      lat_q      <= lat_d;
    end
  end

  // Frame sequencing; next byte is staged only when the current one is taken.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy;
    done_d     = 1'b0;
    freeze_d   = freeze_q;
    sel_d      = sel_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    sum_d      = sum_q;
    lat_d      = lat_q;
    ser_load_c = 1'b0;
    ser_pop_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          freeze_d   = 1'b1;
          sel_d      = '0;
          sum_d      = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = HDR_BYTE;
          state_d    = ST_HDR;
        end
      end
      ST_HDR: begin
        if (accept_c) begin
          tx_valid_d = 1'b0;
          lat_d      = '0;
          state_d    = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (lat_q == LAT_W'(RD_LAT)) begin
          ser_load_c = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = 8'(sel_q);
          state_d    = ST_SEND_IDX;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_SEND_IDX: begin
        if (accept_c) begin
          sum_d     = sum_q ^ tx_data_q;
          ser_pop_c = 1'b1;
          tx_data_d = ser_byte_c;
          state_d   = ST_SEND_DATA;
        end
      end
      ST_SEND_DATA: begin
        if (accept_c) begin
          sum_d = sum_q ^ tx_data_q;
          if (!ser_last_c) begin
            ser_pop_c = 1'b1;
            tx_data_d = ser_byte_c;
          end else if (sel_q == LAST_SEL) begin
            tx_data_d = sum_q ^ tx_data_q;
            state_d   = ST_SEND_SUM;
          end else begin
            tx_valid_d = 1'b0;
            sel_d      = sel_q + SEL_W'(1);
            lat_d      = '0;
            state_d    = ST_RD_WAIT;
          end
        end
      end
      ST_SEND_SUM: begin
        if (accept_c) begin
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          freeze_d   = 1'b0;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        sel_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.freeze   = freeze_q;
  assign bus.hist_sel = sel_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;

`ifdef HIST_CLEAR_ON_READ_EN
  // Clear the bin in the same cycle its final data byte is taken.
  assign bus.bin_clr = (state_q == ST_SEND_DATA) & ser_last_c & accept_c;
`else
  assign bus.bin_clr = 1'b0;
`endif

endmodule
